io_port_bank: RTL and testbench
===============================

# io_port_bank

Parametrised successor to the single-register in/out ports of the Mini-SRC datapath. Provides NUM_PORTS independent input and output channels, each buffered by a FIFO of FIFO_DEPTH words. External devices access the channels through valid/ready handshakes; the datapath accesses them through the bus using a port index and the InPortout/OutPortin strobes. Sticky per-port error flags record bus-side underflow and overflow.

## Interface
- DATA_W, 32, word width of the bus and the channels
- NUM_PORTS, 2, channel count (1..16)
- FIFO_DEPTH, 4, words per FIFO; power of two, at least 2
- PORT_W, $clog2(NUM_PORTS) with a minimum of 1, derived width of the port index

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- clear  in  1  reset, asynchronous, active-high
- port_sel  in  PORT_W  channel index for bus-side access
- InPortout  in  1  pops the selected input FIFO
- bus_rd_data  out  DATA_W  head of the selected input FIFO (show-ahead)
- OutPortin  in  1  pushes BusMuxOut into the selected output FIFO
- BusMuxOut  in  DATA_W  bus value
- ext_in_data  in  NUM_PORTS*DATA_W  producer data; channel k uses bits [k*DATA_W +: DATA_W]
- ext_in_valid  in  NUM_PORTS  producer valid, one bit per channel
- ext_in_ready  out  NUM_PORTS  input FIFO not full
- ext_out_data  out  NUM_PORTS*DATA_W  head of each output FIFO
- ext_out_valid  out  NUM_PORTS  output FIFO not empty
- ext_out_ready  in  NUM_PORTS  consumer ready
- in_empty  out  NUM_PORTS  input FIFO empty
- out_full  out  NUM_PORTS  output FIFO full
- err_flags  out  2*NUM_PORTS  sticky flags; bit 2k = underflow on channel k, bit 2k+1 = overflow on channel k
- err_clr  in  1  clears all err_flags

## Operation
- External input: a word is pushed on a cycle with ext_in_valid[k] and ext_in_ready[k] both high.
- External output: a word is popped on a cycle with ext_out_valid[k] and ext_out_ready[k] both high.
- Bus read: bus_rd_data continuously shows the head of input FIFO port_sel. When that FIFO is empty, bus_rd_data is 0.
  - InPortout with a non-empty FIFO pops it at the edge.
  - InPortout with an empty FIFO does not pop and sets underflow[k].
- Bus write: OutPortin with a non-full output FIFO pushes BusMuxOut at the edge. With a full FIFO the word is dropped and overflow[k] is set.
- port_sel >= NUM_PORTS: reads return 0, and strobes have no effect and set no flags.
- Full/empty and handshake decisions use the count at the start of the cycle.
  - A push to a full FIFO is refused even if a pop occurs in the same cycle.
  - A pop from an empty FIFO is ignored even if a push occurs in the same cycle.
  - On a FIFO that is neither full nor empty, a simultaneous push and pop leaves the count unchanged and both take effect.
- Pointers are log2(FIFO_DEPTH) bits and wrap from DEPTH-1 to 0. The count is log2(FIFO_DEPTH)+1 bits and never exceeds DEPTH.
- err_clr clears all flags. If err_clr and a new error occur in the same cycle, the set wins for that bit.

## Timing
- Reset (clear high, asynchronous) takes effect immediately:
  - all pointers, counts and err_flags go to 0;
  - bus_rd_data = 0, ext_out_data = 0, ext_out_valid = 0;
  - ext_in_ready = all 1, in_empty = all 1, out_full = all 0.
- Reset asserted mid-transfer discards all buffered data.
- External push to bus_rd_data visibility: 1 cycle.
- Bus write to ext_out_valid rising: 1 cycle.
- ext_in_ready, ext_out_valid, in_empty and out_full are derived from registered counts only. None of them depends combinationally on the same cycle's valid/ready inputs.
- bus_rd_data is combinational from port_sel and FIFO state, with no register stage.

## Structure
- Shared package io_port_pkg holds:
  - the default parameter values;
  - the error-bit offsets (ERR_UNDERFLOW = 0, ERR_OVERFLOW = 1);
  - the PORT_W derivation function.
- One sub-module, sync_fifo (params WIDTH, DEPTH; push, pop, head, full, empty, count), instantiated 2*NUM_PORTS times via generate.
- Flag logic and port decode live in the top level.

## Test plan
- Reset, then a 2-port bank at defaults: drive ext_in_valid[1] with 0xDEADBEEF for 1 cycle -> next cycle in_empty[1] = 0, and port_sel = 1 gives bus_rd_data = 0xDEADBEEF. An InPortout pulse then returns in_empty[1] to 1.
- Fill input FIFO 0 with 4 words -> ext_in_ready[0] = 0. A 5th word held valid is not accepted. Pop the 4 words via the bus -> they come out in order, and the 5th word is accepted afterwards.
- InPortout on empty port 0 -> bus_rd_data = 0, err_flags = 0b0001. err_clr in the same cycle as a second underflow -> flag stays 1. err_clr alone -> flag goes to 0.
- Write 5 words via OutPortin to port 1 with ext_out_ready[1] = 0 -> out_full[1] = 1 and err_flags[3] = 1. Release ready -> the first 4 words drain in order.
- Wrap-around: stream 10 words through input FIFO 0, pushing and popping the same cycle while the count is 2 -> order preserved and the count stays 2.
- Assert clear while both FIFOs are partly full -> all outputs take their reset values immediately. Traffic after deassertion starts from empty.

Source files
------------

// File: rtl/io_port_pkg.sv
// -----------------------------------------------------------------------------
// io_port_pkg
// Shared definitions for the I/O port bank:
//   - default parameter values for the bank,
//   - bit offsets of the per-channel error pair inside err_flags,
//   - derivation of the port-index width from the channel count.
// -----------------------------------------------------------------------------
package io_port_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_PORTS  = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    // Channel k owns err_flags[2k +: 2]; these are the offsets within that pair.
    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_OVERFLOW  = 1;

    // A single-channel bank still needs a one-bit index so the port exists.
    function automatic int port_w_calc(input int num_ports);
        if (num_ports <= 1) begin
            return 1;
        end else begin
            return $clog2(num_ports);
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. Push/pop requests are qualified against the
// occupancy at the start of the cycle: a push into a full FIFO and a pop from
// an empty FIFO are ignored, even when the opposite operation happens in the
// same cycle.
// Ports:
//   clock, clear  rising-edge clock, asynchronous active-high reset
//   push, din     write request and data
//   pop           read request (advances past the current head)
//   head          current head word, 0 while empty
//   full, empty   occupancy status derived from the registered count
//   count         number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push & ~full_s;
    assign do_pop_s  = pop & ~empty_s;

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    // Gate the head so stale storage never leaks out of an empty FIFO.
    assign head  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage write; contents need no reset since head is gated by empty.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// -----------------------------------------------------------------------------
// io_port_bank
// NUM_PORTS input and output channels, each buffered by a FIFO_DEPTH-word FIFO.
// External devices use valid/ready per channel; the datapath uses port_sel with
// the InPortout (pop input FIFO) and OutPortin (push BusMuxOut to output FIFO)
// strobes. Sticky err_flags record bus-side underflow and overflow per channel.
// Ports:
//   clock, clear                         clock, asynchronous active-high reset
//   port_sel, InPortout, bus_rd_data     bus read side (show-ahead, combinational)
//   OutPortin, BusMuxOut                 bus write side
//   ext_in_data/valid/ready              producer side of the input FIFOs
//   ext_out_data/valid/ready             consumer side of the output FIFOs
//   in_empty, out_full                   per-channel status
//   err_flags, err_clr                   bit 2k underflow, bit 2k+1 overflow
// -----------------------------------------------------------------------------
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PORT_W     = port_w_calc(NUM_PORTS)
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [PORT_W-1:0]             port_sel,
    input  logic                          InPortout,
    output logic [DATA_W-1:0]             bus_rd_data,
    input  logic                          OutPortin,
    input  logic [DATA_W-1:0]             BusMuxOut,
    input  logic [NUM_PORTS*DATA_W-1:0]   ext_in_data,
    input  logic [NUM_PORTS-1:0]          ext_in_valid,
    output logic [NUM_PORTS-1:0]          ext_in_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   ext_out_data,
    output logic [NUM_PORTS-1:0]          ext_out_valid,
    input  logic [NUM_PORTS-1:0]          ext_out_ready,
    output logic [NUM_PORTS-1:0]          in_empty,
    output logic [NUM_PORTS-1:0]          out_full,
    output logic [2*NUM_PORTS-1:0]        err_flags,
    input  logic                          err_clr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [NUM_PORTS-1:0]   sel_hit_s;
    logic [NUM_PORTS-1:0]   in_pop_s;
    logic [NUM_PORTS-1:0]   in_full_s;
    logic [NUM_PORTS-1:0]   out_push_s;
    logic [NUM_PORTS-1:0]   out_empty_s;
    logic [DATA_W-1:0]      in_head_s   [NUM_PORTS];
    logic [CNT_W-1:0]       in_count_s  [NUM_PORTS];
    logic [CNT_W-1:0]       out_count_s [NUM_PORTS];
    logic [DATA_W-1:0]      bus_rd_s;
    logic [2*NUM_PORTS-1:0] err_set_s;
    logic [2*NUM_PORTS-1:0] err_flags_r;

    // Port decode: an out-of-range port_sel matches no channel, so its strobes
    // touch nothing and its read returns 0.
    always_comb begin
        sel_hit_s = {NUM_PORTS{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            sel_hit_s[k] = (port_sel == PORT_W'(k));
        end
    end

    // Bus read mux as an AND-OR over the one-hot decode.
    always_comb begin
        bus_rd_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            bus_rd_s = bus_rd_s | (in_head_s[k] & {DATA_W{sel_hit_s[k]}});
        end
    end

    assign bus_rd_data = bus_rd_s;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_chan
        assign in_pop_s[g]   = InPortout & sel_hit_s[g];
        assign out_push_s[g] = OutPortin & sel_hit_s[g];

        sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
            .clock (clock),
            .clear (clear),
            .push  (ext_in_valid[g]),
            .pop   (in_pop_s[g]),
            .din   (ext_in_data[g*DATA_W +: DATA_W]),
            .head  (in_head_s[g]),
            .full  (in_full_s[g]),
            .empty (in_empty[g]),
            .count (in_count_s[g])
        );

        sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
            .clock (clock),
            .clear (clear),
            .push  (out_push_s[g]),
            .pop   (ext_out_ready[g]),
            .din   (BusMuxOut),
            .head  (ext_out_data[g*DATA_W +: DATA_W]),
            .full  (out_full[g]),
            .empty (out_empty_s[g]),
            .count (out_count_s[g])
        );

        assign ext_in_ready[g]  = ~in_full_s[g];
        assign ext_out_valid[g] = ~out_empty_s[g];

        // Errors are judged on the start-of-cycle count, like the FIFO itself.
        assign err_set_s[2*g + ERR_UNDERFLOW] = in_pop_s[g] &
                                                (in_count_s[g] == {CNT_W{1'b0}});
        assign err_set_s[2*g + ERR_OVERFLOW]  = out_push_s[g] &
                                                (out_count_s[g] == CNT_FULL);
    end

    // Sticky error flags; a new error in the clearing cycle survives the clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            err_flags_r <= {(2*NUM_PORTS){1'b0}};
        end else if (err_clr) begin
            err_flags_r <= err_set_s;
        end else begin
            err_flags_r <= err_flags_r | err_set_s;
        end
    end

    assign err_flags = err_flags_r;

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

    localparam int DW = 32;
    localparam int NP = 2;
    localparam int D  = 4;

    logic              clock = 1'b0;
    logic              clear;
    logic [0:0]        port_sel;
    logic              InPortout;
    logic [DW-1:0]     bus_rd_data;
    logic              OutPortin;
    logic [DW-1:0]     BusMuxOut;
    logic [NP*DW-1:0]  ext_in_data;
    logic [NP-1:0]     ext_in_valid;
    logic [NP-1:0]     ext_in_ready;
    logic [NP*DW-1:0]  ext_out_data;
    logic [NP-1:0]     ext_out_valid;
    logic [NP-1:0]     ext_out_ready;
    logic [NP-1:0]     in_empty;
    logic [NP-1:0]     out_full;
    logic [2*NP-1:0]   err_flags;
    logic              err_clr;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queues of words per channel plus the flag vector.
    logic [DW-1:0]   in_q  [NP][$];
    logic [DW-1:0]   out_q [NP][$];
    logic [2*NP-1:0] m_err;

    io_port_bank dut (
        .clock         (clock),
        .clear         (clear),
        .port_sel      (port_sel),
        .InPortout     (InPortout),
        .bus_rd_data   (bus_rd_data),
        .OutPortin     (OutPortin),
        .BusMuxOut     (BusMuxOut),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_empty      (in_empty),
        .out_full      (out_full),
        .err_flags     (err_flags),
        .err_clr       (err_clr)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] m_rd();
        if (in_q[port_sel].size() > 0) return in_q[port_sel][0];
        return 32'h0;
    endfunction

    function automatic logic [NP-1:0] m_in_empty();
        logic [NP-1:0] r;
        for (int k = 0; k < NP; k++) r[k] = (in_q[k].size() == 0);
        return r;
    endfunction

    function automatic logic [NP-1:0] m_in_ready();
        logic [NP-1:0] r;
        for (int k = 0; k < NP; k++) r[k] = (in_q[k].size() < D);
        return r;
    endfunction

    function automatic logic [NP-1:0] m_out_valid();
        logic [NP-1:0] r;
        for (int k = 0; k < NP; k++) r[k] = (out_q[k].size() > 0);
        return r;
    endfunction

    function automatic logic [NP-1:0] m_out_full();
        logic [NP-1:0] r;
        for (int k = 0; k < NP; k++) r[k] = (out_q[k].size() == D);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            in_q[k].delete();
            out_q[k].delete();
        end
        m_err = '0;
    endtask

    task automatic idle();
        port_sel = 1'b0; InPortout = 1'b0; OutPortin = 1'b0; BusMuxOut = '0;
        ext_in_data = '0; ext_in_valid = '0; ext_out_ready = '0; err_clr = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic tick();
        logic [2*NP-1:0] set;
        set = '0;
        for (int k = 0; k < NP; k++) begin
            bit hit;
            int isz;
            int osz;
            hit = (int'(port_sel) == k);
            isz = in_q[k].size();
            osz = out_q[k].size();
            if (InPortout && hit && isz == 0) set[2*k] = 1'b1;
            if (OutPortin && hit && osz == D) set[2*k+1] = 1'b1;
            if (InPortout && hit && isz > 0) in_q[k].delete(0);
            if (ext_in_valid[k] && isz < D) in_q[k].push_back(ext_in_data[k*DW +: DW]);
            if (ext_out_ready[k] && osz > 0) out_q[k].delete(0);
            if (OutPortin && hit && osz < D) out_q[k].push_back(BusMuxOut);
        end
        m_err = (err_clr ? '0 : m_err) | set;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus_rd_data !== 32'h0) begin errors++; $display("FAIL reset_bus_rd: got %h want 0", bus_rd_data); end
        checks++; if (ext_out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", ext_out_data); end
        checks++; if (ext_out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b want 00", ext_out_valid); end
        checks++; if (ext_in_ready !== 2'b11) begin errors++; $display("FAIL reset_in_ready: got %b want 11", ext_in_ready); end
        checks++; if (in_empty !== 2'b11) begin errors++; $display("FAIL reset_in_empty: got %b want 11", in_empty); end
        checks++; if (out_full !== 2'b00) begin errors++; $display("FAIL reset_out_full: got %b want 00", out_full); end
        checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b want 0000", err_flags); end
        clear = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        ext_in_data = {32'hDEADBEEF, 32'h0};
        ext_in_valid = 2'b10;
        tick();
        ext_in_valid = 2'b00;
        port_sel = 1'b1;
        #1;
        checks++; if (in_empty[1] !== 1'b0) begin errors++; $display("FAIL basic_not_empty: got %b want 0", in_empty[1]); end
        checks++; if (bus_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd: got %h want deadbeef", bus_rd_data); end
        InPortout = 1'b1;
        tick();
        InPortout = 1'b0;
        #1;
        checks++; if (in_empty[1] !== 1'b1) begin errors++; $display("FAIL basic_empty_again: got %b want 1", in_empty[1]); end
        checks++; if (bus_rd_data !== 32'h0) begin errors++; $display("FAIL basic_rd_empty: got %h want 0", bus_rd_data); end
        idle();
    endtask

    task automatic test_fill();
        logic [DW-1:0] w [5];
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        port_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ext_in_data[31:0] = w[i];
            ext_in_valid = 2'b01;
            tick();
        end
        ext_in_data[31:0] = w[4];
        #1;
        checks++; if (ext_in_ready[0] !== 1'b0) begin errors++; $display("FAIL fill_ready_low: got %b want 0", ext_in_ready[0]); end
        tick();
        checks++; if (bus_rd_data !== w[0]) begin errors++; $display("FAIL fill_head_kept: got %h want %h", bus_rd_data, w[0]); end
        checks++; if (ext_in_ready[0] !== 1'b0) begin errors++; $display("FAIL fill_5th_refused: got %b want 0", ext_in_ready[0]); end
        // First pop with the 5th word still offered: push is refused (full at start).
        InPortout = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus_rd_data !== w[i]) begin errors++; $display("FAIL fill_pop_order[%0d]: got %h want %h", i, bus_rd_data, w[i]); end
            tick();
            ext_in_valid = 2'b00;
        end
        InPortout = 1'b0;
        #1;
        checks++; if (in_empty[0] !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b want 1", in_empty[0]); end
        ext_in_valid = 2'b01;
        tick();
        ext_in_valid = 2'b00;
        #1;
        checks++; if (bus_rd_data !== w[4]) begin errors++; $display("FAIL fill_5th_later: got %h want %h", bus_rd_data, w[4]); end
        InPortout = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_underflow();
        logic [DW-1:0] v;
        v = $urandom;
        port_sel = 1'b0;
        InPortout = 1'b1;
        #1;
        checks++; if (bus_rd_data !== 32'h0) begin errors++; $display("FAIL uf_rd_zero: got %h want 0", bus_rd_data); end
        tick();
        InPortout = 1'b0;
        #1;
        checks++; if (err_flags !== 4'b0001) begin errors++; $display("FAIL uf_flag: got %b want 0001", err_flags); end
        InPortout = 1'b1; err_clr = 1'b1;
        tick();
        InPortout = 1'b0; err_clr = 1'b0;
        #1;
        checks++; if (err_flags !== 4'b0001) begin errors++; $display("FAIL uf_set_wins: got %b want 0001", err_flags); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL uf_clr: got %b want 0000", err_flags); end
        // Pop on empty with a same-cycle push: pop ignored, push lands, flag set.
        ext_in_data[31:0] = v; ext_in_valid = 2'b01; InPortout = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (err_flags !== 4'b0001) begin errors++; $display("FAIL uf_push_same: got %b want 0001", err_flags); end
        checks++; if (bus_rd_data !== v) begin errors++; $display("FAIL uf_push_kept: got %h want %h", bus_rd_data, v); end
        InPortout = 1'b1; err_clr = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] v [5];
        for (int i = 0; i < 5; i++) v[i] = $urandom;
        port_sel = 1'b1;
        ext_out_ready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            BusMuxOut = v[i];
            OutPortin = 1'b1;
            tick();
            if (i == 0) begin
                checks++; if (ext_out_valid[1] !== 1'b1) begin errors++; $display("FAIL of_valid_1cyc: got %b want 1", ext_out_valid[1]); end
            end
        end
        OutPortin = 1'b0;
        #1;
        checks++; if (out_full[1] !== 1'b1) begin errors++; $display("FAIL of_full: got %b want 1", out_full[1]); end
        checks++; if (err_flags !== 4'b1000) begin errors++; $display("FAIL of_flag: got %b want 1000", err_flags); end
        ext_out_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (ext_out_data[63:32] !== v[i] || ext_out_valid[1] !== 1'b1) begin errors++; $display("FAIL of_drain[%0d]: got %h/%b want %h/1", i, ext_out_data[63:32], ext_out_valid[1], v[i]); end
            tick();
        end
        ext_out_ready = 2'b00;
        #1;
        checks++; if (ext_out_valid[1] !== 1'b0) begin errors++; $display("FAIL of_drained: got %b want 0", ext_out_valid[1]); end
        err_clr = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_wrap();
        port_sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ext_in_data[31:0] = 32'hA000_0000 + 32'(i);
            ext_in_valid = 2'b01;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            ext_in_data[31:0] = 32'hA000_0000 + 32'(i + 2);
            ext_in_valid = 2'b01;
            InPortout = 1'b1;
            #1;
            checks++; if (bus_rd_data !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, bus_rd_data, 32'hA000_0000 + 32'(i)); end
            tick();
            checks++; if (in_q[0].size() != 2 || in_empty[0] !== 1'b0 || ext_in_ready[0] !== 1'b1) begin errors++; $display("FAIL wrap_count[%0d]: got empty=%b ready=%b want 0/1 (model size %0d)", i, in_empty[0], ext_in_ready[0], in_q[0].size()); end
        end
        ext_in_valid = 2'b00;
        for (int i = 10; i < 12; i++) begin
            #1;
            checks++; if (bus_rd_data !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL wrap_tail[%0d]: got %h want %h", i, bus_rd_data, 32'hA000_0000 + 32'(i)); end
            tick();
        end
        InPortout = 1'b0;
        #1;
        checks++; if (in_empty[0] !== 1'b1) begin errors++; $display("FAIL wrap_end_empty: got %b want 1", in_empty[0]); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            port_sel      = 1'($urandom_range(0, 1));
            InPortout     = ($urandom_range(0, 2) == 0);
            OutPortin     = ($urandom_range(0, 2) == 0);
            BusMuxOut     = $urandom;
            ext_in_data   = {$urandom, $urandom};
            ext_in_valid  = 2'($urandom);
            ext_out_ready = 2'($urandom);
            err_clr       = ($urandom_range(0, 7) == 0);
            #1;
            checks++; if (bus_rd_data !== m_rd()) begin errors++; $display("FAIL rnd_rd[%0d]: got %h want %h", n, bus_rd_data, m_rd()); end
            checks++; if (in_empty !== m_in_empty()) begin errors++; $display("FAIL rnd_in_empty[%0d]: got %b want %b", n, in_empty, m_in_empty()); end
            checks++; if (ext_in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, ext_in_ready, m_in_ready()); end
            checks++; if (ext_out_valid !== m_out_valid()) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", n, ext_out_valid, m_out_valid()); end
            checks++; if (out_full !== m_out_full()) begin errors++; $display("FAIL rnd_out_full[%0d]: got %b want %b", n, out_full, m_out_full()); end
            checks++; if (err_flags !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err_flags, m_err); end
            for (int k = 0; k < NP; k++) begin
                if (out_q[k].size() > 0) begin
                    checks++; if (ext_out_data[k*DW +: DW] !== out_q[k][0]) begin errors++; $display("FAIL rnd_out_data[%0d][%0d]: got %h want %h", n, k, ext_out_data[k*DW +: DW], out_q[k][0]); end
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_clear_mid();
        logic [DW-1:0] v;
        v = $urandom;
        ext_in_data = {$urandom, $urandom};
        ext_in_valid = 2'b11;
        port_sel = 1'b1; OutPortin = 1'b1; BusMuxOut = $urandom;
        tick();
        tick();
        idle();
        #1;
        clear = 1'b1;
        #1;
        checks++; if (bus_rd_data !== 32'h0 || ext_out_data !== 64'h0 || ext_out_valid !== 2'b00) begin errors++; $display("FAIL clr_data: got rd=%h out=%h v=%b want 0/0/00", bus_rd_data, ext_out_data, ext_out_valid); end
        checks++; if (ext_in_ready !== 2'b11 || in_empty !== 2'b11 || out_full !== 2'b00 || err_flags !== 4'b0000) begin errors++; $display("FAIL clr_status: got rdy=%b emp=%b full=%b err=%b want 11/11/00/0000", ext_in_ready, in_empty, out_full, err_flags); end
        model_reset();
        @(posedge clock);
        #1;
        clear = 1'b0;
        ext_in_data = {v, 32'h0};
        ext_in_valid = 2'b10;
        tick();
        idle();
        port_sel = 1'b1;
        #1;
        checks++; if (bus_rd_data !== v || in_empty !== 2'b01) begin errors++; $display("FAIL clr_restart: got rd=%h emp=%b want %h/01", bus_rd_data, in_empty, v); end
        checks++; if (ext_out_valid !== 2'b00) begin errors++; $display("FAIL clr_out_empty: got %b want 00", ext_out_valid); end
    endtask

    initial begin
        clear = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_basic();
        test_fill();
        test_underflow();
        test_overflow();
        test_wrap();
        test_random();
        test_clear_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
